// File: rtl/pc_stack_unit.sv
// Program counter and hardware return stack: registers the fetch address, applies
// branch/return/PCL updates from decode, and flags the wasted fetch slot behind them.
package pc_stack_pkg;
    typedef enum logic [1:0] {
        PC_UPDATE_INC     = 2'd0,
        PC_UPDATE_JUMP    = 2'd1,
        PC_UPDATE_RET     = 2'd2,
        PC_UPDATE_PCL_MOD = 2'd3
    } pc_update_sel_t;
endpackage

module pc_stack_unit
    import pc_stack_pkg::*;
#(
    parameter logic [11:0] RESET_VEC   = 12'h7FF,
    parameter int          STACK_DEPTH = 2,
    localparam int         DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inst_valid_in,
    input  logic [1:0]    pc_update_sel_in,
    input  logic [11:0]   jump_addr_in,
    input  logic          stack_push_in,
    input  logic          stack_pop_in,
    input  logic          skip_in,
    input  logic [1:0]    page_in,
    input  logic [7:0]    pcl_data_in,
    output logic [11:0]   pc_out,
    output logic [7:0]    pcl_out,
    output logic          flush_out,
    output logic [DW-1:0] stack_depth_out,
    output logic          stack_ovf_out,
    output logic          stack_unf_out
);

    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    pc_update_sel_t sel;
    assign sel = pc_update_sel_t'(pc_update_sel_in);

    logic [11:0]   pc_q, pc_d;
    logic          flush_q, flush_d;
    logic [11:0]   stack_q [STACK_DEPTH];
    logic [11:0]   stack_d [STACK_DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // The return address is the current fetch address: while A executes, A+1 is in fetch.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        pc_d    = pc_q + 12'd1;
        flush_d = 1'b0;

        if (inst_valid_in) begin
            unique case (sel)
                PC_UPDATE_INC: flush_d = skip_in;
                PC_UPDATE_JUMP: begin
                    pc_d    = jump_addr_in;
                    flush_d = 1'b1;
                end
                PC_UPDATE_RET: begin
                    pc_d    = stack_q[0];
                    flush_d = 1'b1;
                end
                PC_UPDATE_PCL_MOD: begin
                    pc_d    = {1'b0, page_in, 1'b0, pcl_data_in};
                    flush_d = 1'b1;
                end
            endcase

            // Push wins over a simultaneous pop; flags follow whichever operation ran.
            if (stack_push_in) begin
                for (int i = STACK_DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
                stack_d[0] = pc_q;
                if (depth_q == FULL) ovf_d   = 1'b1;
                else                 depth_d = depth_q + DW'(1);
            end else if (stack_pop_in) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                if (depth_q == '0) unf_d   = 1'b1;
                else               depth_d = depth_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            flush_q <= 1'b1;
            // NOTE: the return stack is a handful of flops, so it is cleared on reset like any other state.
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 12'h000;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc_out          = pc_q;
    assign pcl_out         = pc_q[7:0];
    assign flush_out       = flush_q;
    assign stack_depth_out = depth_q;
    assign stack_ovf_out   = ovf_q;
    assign stack_unf_out   = unf_q;

endmodule
